// File: rtl/mem_pkg.sv
// Shared types and sizing helpers for the memory target; `WIDTH/`ADDR_WIDTH default to 16/5.
`ifndef WIDTH
`define WIDTH 16
`endif
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 5
`endif

package mem_pkg;

  typedef enum logic {IDLE, BUSY} mem_state_e;

  typedef logic [`WIDTH-1:0]      word_t;
  typedef logic [`ADDR_WIDTH-1:0] addr_t;

  localparam int WR_LAT_DFLT = 1;
  localparam int RD_LAT_DFLT = 2;

  // Counter must hold max(WR_LAT,RD_LAT)-1 and still be at least one bit wide.
  function automatic int cnt_width(input int wr_lat, input int rd_lat);
    int m;
    m = (wr_lat > rd_lat) ? wr_lat : rd_lat;
    return $clog2(m + 1);
  endfunction

  localparam int CNT_W = cnt_width(WR_LAT_DFLT, RD_LAT_DFLT);

endpackage

// File: rtl/mem_array.sv
// DEPTH x WIDTH storage: async clear, one write port, one registered read port.
// With MEM_PARITY_EN a per-word even-parity column is kept and checked on every read.
`ifndef WIDTH
`define WIDTH 16
`endif
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 5
`endif

module mem_array #(
  parameter int WIDTH      = `WIDTH,
  parameter int ADDR_WIDTH = `ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  res,
  input  logic                  i_we,
  input  logic                  i_re,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic [WIDTH-1:0]      i_wdata,
`ifdef MEM_PARITY_EN
  output logic                  o_parity_err,
`endif
  output logic [WIDTH-1:0]      o_rdata
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_rdata;

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_rdata <= '0;
    end else begin
      if (i_we) r_mem[i_addr] <= i_wdata;
      if (i_re) r_rdata <= r_mem[i_addr];
    end
  end

  assign o_rdata = r_rdata;

`ifdef MEM_PARITY_EN
  logic r_par [DEPTH];
  logic r_parity_err;

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      for (int i = 0; i < DEPTH; i++) r_par[i] <= 1'b0;
      r_parity_err <= 1'b0;
    end else begin
      if (i_we) r_par[i_addr] <= ^i_wdata;
      if (i_re) r_parity_err <= (^r_mem[i_addr]) != r_par[i_addr];
    end
  end

  assign o_parity_err = r_parity_err;
`endif

endmodule

// File: rtl/mem_slave_ctrl.sv
// Memory target FSM: accepts one request when idle, stretches it over WR_LAT/RD_LAT cycles, then commits.
// Optional parity checking is enabled with MEM_PARITY_EN.
`ifndef WIDTH
`define WIDTH 16
`endif
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 5
`endif

module mem_slave_ctrl
  import mem_pkg::*;
#(
  parameter int WIDTH      = `WIDTH,
  parameter int ADDR_WIDTH = `ADDR_WIDTH,
  parameter int WR_LAT     = 1,
  parameter int RD_LAT     = 2
) (
  input  logic                  clk,
  input  logic                  res,
  input  logic                  wr_rd,
  input  logic                  valid,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [WIDTH-1:0]      wdata,
  output logic [WIDTH-1:0]      rdata,
`ifdef MEM_PARITY_EN
  output logic                  parity_err,
`endif
  output logic                  ready
);

  localparam int CNT_W = cnt_width(WR_LAT, RD_LAT);
  localparam logic [CNT_W-1:0] WR_INIT = CNT_W'(WR_LAT - 1);
  localparam logic [CNT_W-1:0] RD_INIT = CNT_W'(RD_LAT - 1);

  mem_state_e            r_state;
  logic                  r_ready;
  logic [CNT_W-1:0]      r_cnt;
  logic                  r_wr;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [WIDTH-1:0]      r_wdata;

  logic w_commit;
  logic w_we;
  logic w_re;

  assign w_commit = (r_state == BUSY) && (r_cnt == '0);
  assign w_we     = w_commit && r_wr;
  assign w_re     = w_commit && !r_wr;

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      r_state <= IDLE;
      r_ready <= 1'b0;
      r_cnt   <= '0;
      r_wr    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          // ready rises one edge after reset release before anything is accepted
          if (!r_ready) begin
            r_ready <= 1'b1;
          end else if (valid) begin
            r_wr    <= wr_rd;
            r_addr  <= addr;
            r_wdata <= wdata;
            r_ready <= 1'b0;
            r_state <= BUSY;
            r_cnt   <= wr_rd ? WR_INIT : RD_INIT;
          end
        end
        BUSY: begin
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - CNT_W'(1);
          end else begin
            r_state <= IDLE;
            r_ready <= 1'b1;
          end
        end
      endcase
    end
  end

  assign ready = r_ready;

  mem_array #(
    .WIDTH      (WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_array (
    .clk          (clk),
    .res          (res),
    .i_we         (w_we),
    .i_re         (w_re),
    .i_addr       (r_addr),
    .i_wdata      (r_wdata),
`ifdef MEM_PARITY_EN
    .o_parity_err (parity_err),
`endif
    .o_rdata      (rdata)
  );

endmodule

// File: tb/tb_mem_slave_ctrl.sv
// Directed bench for mem_slave_ctrl: table of single accesses plus hand sequences for corner cases.
`timescale 1ns/1ps
module tb_mem_slave_ctrl;

  logic        clk;
  logic        res;
  logic        wr_rd;
  logic        valid;
  logic [4:0]  addr;
  logic [15:0] wdata;
  logic [15:0] rdata;
  logic        ready;
`ifdef MEM_PARITY_EN
  logic        parity_err;
`endif

  int checks   = 0;
  int failures = 0;

  mem_slave_ctrl dut (
    .clk        (clk),
    .res        (res),
    .wr_rd      (wr_rd),
    .valid      (valid),
    .addr       (addr),
    .wdata      (wdata),
    .rdata      (rdata),
`ifdef MEM_PARITY_EN
    .parity_err (parity_err),
`endif
    .ready      (ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic [4:0]  a;
    logic [15:0] d;
    int          lat;
    logic [15:0] exp_rdata;
  } vec_t;

  vec_t vecs [10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(output bit ok);
    int n;
    n = 0;
    while (!ready && n < 20) begin
      tick();
      n++;
    end
    ok = ready;
  endtask

  // Issues one access and returns how many edges ready stayed low after acceptance.
  task automatic do_access(input logic wr, input logic [4:0] a, input logic [15:0] d, output int cycles);
    bit ok;
    wait_ready(ok);
    if (!ok) begin
      checks++;
      failures++;
      $display("FAIL ready_timeout: got ready=0 expected ready=1 before access");
    end
    wr_rd = wr;
    addr  = a;
    wdata = d;
    valid = 1'b1;
    tick();
    valid  = 1'b0;
    cycles = 0;
    while (!ready && cycles < 20) begin
      tick();
      cycles++;
    end
  endtask

  initial begin
    int   cyc;
    int   acc_cyc [4];
    int   n_acc;
    logic rdy_before;
    bit   ok;

    vecs[0] = '{1'b1, 5'd5,  16'hA5A5, 1, 16'h0000};
    vecs[1] = '{1'b0, 5'd5,  16'h0000, 2, 16'hA5A5};
    vecs[2] = '{1'b1, 5'd31, 16'h1234, 1, 16'hA5A5};
    vecs[3] = '{1'b0, 5'd31, 16'h0000, 2, 16'h1234};
    vecs[4] = '{1'b1, 5'd0,  16'hFFFF, 1, 16'h1234};
    vecs[5] = '{1'b0, 5'd0,  16'h0000, 2, 16'hFFFF};
    vecs[6] = '{1'b0, 5'd10, 16'h0000, 2, 16'h0000};
    vecs[7] = '{1'b1, 5'd5,  16'h0000, 1, 16'h0000};
    vecs[8] = '{1'b0, 5'd31, 16'h0000, 2, 16'h1234};
    vecs[9] = '{1'b0, 5'd5,  16'h0000, 2, 16'h0000};

    // Reset held with valid asserted
    res   = 1'b0;
    valid = 1'b1;
    wr_rd = 1'b1;
    addr  = 5'd1;
    wdata = 16'h1111;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("reset_ready", {31'd0, ready}, 32'd0);
      check("reset_rdata", {16'd0, rdata}, 32'd0);
    end
    valid = 1'b0;
    @(negedge clk);
    res = 1'b1;
    tick();
    check("ready_after_release", {31'd0, ready}, 32'd1);

    // Table of single accesses: latency and rdata after each completes
    for (int i = 0; i < 10; i++) begin
      do_access(vecs[i].wr, vecs[i].a, vecs[i].d, cyc);
      check($sformatf("vec%0d_lat", i), cyc, vecs[i].lat);
      check($sformatf("vec%0d_rdata", i), {16'd0, rdata}, {16'd0, vecs[i].exp_rdata});
    end

    // Read data must not appear one edge early
    do_access(1'b1, 5'd12, 16'h0C0C, cyc);
    wr_rd = 1'b0;
    addr  = 5'd12;
    valid = 1'b1;
    tick();
    valid = 1'b0;
    tick();
    check("rd_early_rdata", {16'd0, rdata}, 32'h0000);
    check("rd_early_ready", {31'd0, ready}, 32'd0);
    tick();
    check("rd_done_rdata", {16'd0, rdata}, 32'h0C0C);
    check("rd_done_ready", {31'd0, ready}, 32'd1);

    // Back-to-back writes with valid held high
    n_acc = 0;
    cyc   = 0;
    wr_rd = 1'b1;
    addr  = 5'd0;
    wdata = 16'd1;
    valid = 1'b1;
    while (n_acc < 4 && cyc < 40) begin
      rdy_before = ready;
      tick();
      cyc++;
      if (rdy_before) begin
        acc_cyc[n_acc] = cyc;
        n_acc++;
        addr  = 5'(n_acc);
        wdata = 16'(n_acc + 1);
      end
    end
    valid = 1'b0;
    check("b2b_accept_count", n_acc, 4);
    for (int i = 1; i < 4; i++)
      check($sformatf("b2b_spacing%0d", i), acc_cyc[i] - acc_cyc[i-1], 2);
    for (int i = 0; i < 4; i++) begin
      do_access(1'b0, 5'(i), 16'h0, cyc);
      check($sformatf("b2b_readback%0d", i), {16'd0, rdata}, i + 1);
    end

    // valid pulsed while busy must be dropped
    do_access(1'b1, 5'd9, 16'h0055, cyc);
    wr_rd = 1'b0;
    addr  = 5'd9;
    valid = 1'b1;
    tick();
    wr_rd = 1'b1;
    wdata = 16'hBEEF;
    tick();
    valid = 1'b0;
    tick();
    check("ignored_rdata", {16'd0, rdata}, 32'h0055);
    tick();
    tick();
    check("ignored_ready_idle", {31'd0, ready}, 32'd1);
    do_access(1'b0, 5'd9, 16'h0, cyc);
    check("ignored_mem_unchanged", {16'd0, rdata}, 32'h0055);

    // Reset while a write is in flight
    wait_ready(ok);
    wr_rd = 1'b1;
    addr  = 5'd7;
    wdata = 16'hFFFF;
    valid = 1'b1;
    tick();
    valid = 1'b0;
    res   = 1'b0;
    #1;
    check("midreset_ready", {31'd0, ready}, 32'd0);
    check("midreset_rdata", {16'd0, rdata}, 32'd0);
    tick();
    tick();
    @(negedge clk);
    res = 1'b1;
    tick();
    check("midreset_restart_ready", {31'd0, ready}, 32'd1);
    do_access(1'b0, 5'd7, 16'h0, cyc);
    check("midreset_addr7", {16'd0, rdata}, 32'h0000);
    do_access(1'b0, 5'd9, 16'h0, cyc);
    check("midreset_cleared9", {16'd0, rdata}, 32'h0000);

`ifdef MEM_PARITY_EN
    do_access(1'b1, 5'd2, 16'h0001, cyc);
    dut.u_array.r_par[2] = ~dut.u_array.r_par[2];
    do_access(1'b0, 5'd2, 16'h0, cyc);
    check("parity_err_set", {31'd0, parity_err}, 32'd1);
    check("parity_rdata", {16'd0, rdata}, 32'h0001);
    do_access(1'b0, 5'd9, 16'h0, cyc);
    check("parity_err_clear", {31'd0, parity_err}, 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
